// File: rtl/parser_head_gen.sv
// parser_head_gen
// Front-end of the parser pipeline. It turns a sop/eop framed beat stream
// into one tagged head vector plus a tagged initial metadata vector per
// packet, and counts emitted heads and framing errors.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_data_valid        beat valid (accepted every cycle, no backpressure)
//   i_data_sop/_eop     first / last beat of a packet
//   i_data_bytes        valid bytes on the eop beat (0 = full beat)
//   i_data              beat data, byte 0 in the MSBs
//   o_head              {head, tag}, non-zero for one cycle per packet
//   o_meta              {byte count (16b), zeros, tag}
//   o_pkt_cnt           heads emitted (wraps at 2^32)
//   o_err_cnt           framing errors (wraps at 2^32)
module parser_head_gen #(
   parameter int DATA_WIDTH = 128,
   parameter int HEAD_WIDTH = 512,
   parameter int META_WIDTH = 256,
   parameter int TAG_WIDTH  = 8
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic                               i_data_valid,
   input  logic                               i_data_sop,
   input  logic                               i_data_eop,
   input  logic [$clog2(DATA_WIDTH/8):0]      i_data_bytes,
   input  logic [DATA_WIDTH-1:0]              i_data,
   output logic [HEAD_WIDTH+TAG_WIDTH-1:0]    o_head,
   output logic [META_WIDTH+TAG_WIDTH-1:0]    o_meta,
   output logic [31:0]                        o_pkt_cnt,
   output logic [31:0]                        o_err_cnt
);

   localparam int HEAD_BEATS = HEAD_WIDTH / DATA_WIDTH;
   localparam int DATA_BYTES = DATA_WIDTH / 8;
   localparam int HEAD_BYTES = HEAD_WIDTH / 8;
   localparam int BYTES_W    = $clog2(DATA_BYTES) + 1;
   localparam int BEAT_W     = (HEAD_BEATS > 1) ? $clog2(HEAD_BEATS) : 1;
   localparam int ID_W       = TAG_WIDTH - 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2
   } state_e;

   // Zero every byte at index >= nbytes; nbytes == 0 keeps the whole beat.
   function automatic logic [DATA_WIDTH-1:0] mask_tail(
      input logic [DATA_WIDTH-1:0] data,
      input logic [BYTES_W-1:0]    nbytes
   );
      logic [DATA_WIDTH-1:0] r;
      r = data;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if ((nbytes != '0) && (i >= int'(nbytes))) begin
            r[DATA_WIDTH-1-8*i -: 8] = 8'h00;
         end else begin
            r[DATA_WIDTH-1-8*i -: 8] = data[DATA_WIDTH-1-8*i -: 8];
         end
      end
      return r;
   endfunction

   state_e                          state_q, state_d;
   logic [BEAT_W-1:0]               beat_q, beat_d;
   logic [HEAD_WIDTH-1:0]           buf_q, buf_d;
   logic [ID_W-1:0]                 pkt_id_q, pkt_id_d;
   logic [HEAD_WIDTH+TAG_WIDTH-1:0] head_q, head_d;
   logic [META_WIDTH+TAG_WIDTH-1:0] meta_q, meta_d;
   logic [31:0]                     pkt_cnt_q, pkt_cnt_d;
   logic [31:0]                     err_cnt_q, err_cnt_d;

   logic [BEAT_W-1:0]               slot_s;
   logic                            last_slot_s;
   logic                            accept_s;
   logic                            emit_s;
   logic                            err_s;
   logic [DATA_WIDTH-1:0]           beat_s;
   logic [HEAD_WIDTH-1:0]           head_s;
   logic [META_WIDTH-1:0]           meta_s;
   logic [TAG_WIDTH-1:0]            tag_s;
   int                              beat_bytes_s;
   int                              byte_cnt_s;

   // A sop always restarts at slot 0, otherwise the beat lands at the running slot.
   assign slot_s      = i_data_sop ? '0 : beat_q;
   assign last_slot_s = (slot_s == BEAT_W'(HEAD_BEATS - 1));
   // A sop beat starts a packet in any state; non-sop beats only count in COLLECT.
   assign accept_s    = i_data_valid && (i_data_sop || (state_q == ST_COLLECT));
   assign emit_s      = accept_s && (i_data_eop || last_slot_s);
   // sop outside IDLE or non-sop in IDLE: exactly one error per beat.
   assign err_s       = i_data_valid && (i_data_sop ? (state_q != ST_IDLE) : (state_q == ST_IDLE));
   assign tag_s       = {1'b1, pkt_id_q};

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      if (!i_data_valid) begin
         state_d = state_q;
      end else if (i_data_sop) begin
         if (i_data_eop) begin
            state_d = ST_IDLE;
         end else if (last_slot_s) begin
            state_d = ST_DRAIN;
         end else begin
            state_d = ST_COLLECT;
         end
      end else begin
         case (state_q)
            ST_IDLE:    state_d = ST_IDLE;
            ST_COLLECT: state_d = i_data_eop ? ST_IDLE : (last_slot_s ? ST_DRAIN : ST_COLLECT);
            ST_DRAIN:   state_d = i_data_eop ? ST_IDLE : ST_DRAIN;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   // FSM outputs: head assembly, byte count, next values of datapath flops.
   always_comb begin
      beat_s = mask_tail(i_data, i_data_eop ? i_data_bytes : BYTES_W'(0));
      head_s = i_data_sop ? '0 : buf_q;
      for (int j = 0; j < HEAD_BEATS; j++) begin
         if (BEAT_W'(j) == slot_s) begin
            head_s[HEAD_WIDTH-1-j*DATA_WIDTH -: DATA_WIDTH] = beat_s;
         end else begin
            head_s[HEAD_WIDTH-1-j*DATA_WIDTH -: DATA_WIDTH] = head_s[HEAD_WIDTH-1-j*DATA_WIDTH -: DATA_WIDTH];
         end
      end

      if (i_data_eop && (i_data_bytes != '0) && (int'(i_data_bytes) < DATA_BYTES)) begin
         beat_bytes_s = int'(i_data_bytes);
      end else begin
         beat_bytes_s = DATA_BYTES;
      end
      byte_cnt_s = int'(slot_s) * DATA_BYTES + beat_bytes_s;
      if (byte_cnt_s > HEAD_BYTES) begin
         byte_cnt_s = HEAD_BYTES;
      end else begin
         byte_cnt_s = byte_cnt_s;
      end
      meta_s = '0;
      meta_s[META_WIDTH-1 -: 16] = 16'(byte_cnt_s);

      // Buffer is cleared on emission so DRAIN/IDLE always hold an empty head.
      if (accept_s && !emit_s) begin
         beat_d = slot_s + BEAT_W'(1);
         buf_d  = head_s;
      end else if (emit_s) begin
         beat_d = '0;
         buf_d  = '0;
      end else begin
         beat_d = beat_q;
         buf_d  = buf_q;
      end

      if (emit_s) begin
         head_d    = {head_s, tag_s};
         meta_d    = {meta_s, tag_s};
         pkt_id_d  = pkt_id_q + ID_W'(1);
         pkt_cnt_d = pkt_cnt_q + 32'd1;
      end else begin
         head_d    = '0;
         meta_d    = '0;
         pkt_id_d  = pkt_id_q;
         pkt_cnt_d = pkt_cnt_q;
      end

      if (err_s) begin
         err_cnt_d = err_cnt_q + 32'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         beat_q    <= '0;
         buf_q     <= '0;
         pkt_id_q  <= '0;
         head_q    <= '0;
         meta_q    <= '0;
         pkt_cnt_q <= 32'd0;
         err_cnt_q <= 32'd0;
      end else begin
         beat_q    <= beat_d;
         buf_q     <= buf_d;
         pkt_id_q  <= pkt_id_d;
         head_q    <= head_d;
         meta_q    <= meta_d;
         pkt_cnt_q <= pkt_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign o_head    = head_q;
   assign o_meta    = meta_q;
   assign o_pkt_cnt = pkt_cnt_q;
   assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_parser_head_gen.sv
// Self-checking bench for parser_head_gen: a packet-level byte-queue model
// predicts every output each cycle, and a few literal expectations pin it.
module tb_parser_head_gen;

   localparam int DW = 128;
   localparam int HW = 512;
   localparam int MW = 256;
   localparam int TW = 8;
   localparam int HB = HW / DW;

   logic            i_clk = 1'b0;
   logic            i_rst_n = 1'b0;
   logic            i_data_valid = 1'b0;
   logic            i_data_sop = 1'b0;
   logic            i_data_eop = 1'b0;
   logic [4:0]      i_data_bytes = 5'd0;
   logic [DW-1:0]   i_data = '0;
   logic [HW+TW-1:0] o_head;
   logic [MW+TW-1:0] o_meta;
   logic [31:0]     o_pkt_cnt;
   logic [31:0]     o_err_cnt;

   int n_total = 0;
   int n_pass  = 0;

   // model state: packet-level view only
   logic [7:0]      mq[$];
   bit              m_in_pkt = 1'b0;
   bit              m_done   = 1'b0;
   int              m_beats  = 0;
   int              m_id     = 0;
   logic [31:0]     m_pkt    = 32'd0;
   logic [31:0]     m_err    = 32'd0;
   logic [HW+TW-1:0] exp_head = '0;
   logic [MW+TW-1:0] exp_meta = '0;

   parser_head_gen #(.DATA_WIDTH(DW), .HEAD_WIDTH(HW), .META_WIDTH(MW), .TAG_WIDTH(TW)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data_valid(i_data_valid),
      .i_data_sop(i_data_sop), .i_data_eop(i_data_eop), .i_data_bytes(i_data_bytes),
      .i_data(i_data), .o_head(o_head), .o_meta(o_meta),
      .o_pkt_cnt(o_pkt_cnt), .o_err_cnt(o_err_cnt)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [HW+TW-1:0] act, input logic [HW+TW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s act=%h exp=%h", name, act, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      m_in_pkt = 1'b0; m_done = 1'b0; m_beats = 0; m_id = 0;
      m_pkt = 32'd0; m_err = 32'd0; exp_head = '0; exp_meta = '0;
   endtask

   task automatic model_step();
      int n;
      logic [HW-1:0] h;
      logic [TW-1:0] t;
      exp_head = '0;
      exp_meta = '0;
      if (!i_rst_n) begin
         model_reset();
         return;
      end
      if (!i_data_valid) return;
      if (i_data_sop) begin
         if (m_in_pkt) m_err++;
         m_in_pkt = 1'b1; m_done = 1'b0; m_beats = 0; mq.delete();
      end else if (!m_in_pkt) begin
         m_err++;
      end
      if (m_in_pkt) begin
         if (!m_done) begin
            n = (i_data_eop && i_data_bytes != 5'd0 && i_data_bytes < 5'd16) ? int'(i_data_bytes) : DW / 8;
            for (int i = 0; i < n; i++) mq.push_back(i_data[DW-1-8*i -: 8]);
            m_beats++;
            if (i_data_eop || m_beats == HB) begin
               h = '0;
               for (int i = 0; i < mq.size() && i < HW / 8; i++) h[HW-1-8*i -: 8] = mq[i];
               t = {1'b1, 7'(m_id)};
               exp_head = {h, t};
               exp_meta = '0;
               exp_meta[MW+TW-1 -: 16] = 16'((mq.size() > HW / 8) ? HW / 8 : mq.size());
               exp_meta[TW-1:0] = t;
               m_id = (m_id + 1) % 128;
               m_pkt++;
               m_done = 1'b1;
            end
         end
         if (i_data_eop) m_in_pkt = 1'b0;
      end
   endtask

   always @(posedge i_clk) model_step();
   always @(negedge i_rst_n) model_reset();

   // per-cycle compare of every output against the model
   always @(negedge i_clk) begin
      if (i_rst_n) begin
         chk("model_head", o_head, exp_head);
         chk("model_meta", (HW+TW)'(o_meta), (HW+TW)'(exp_meta));
         chk("model_pkt_cnt", (HW+TW)'(o_pkt_cnt), (HW+TW)'(m_pkt));
         chk("model_err_cnt", (HW+TW)'(o_err_cnt), (HW+TW)'(m_err));
      end
   end

   // drive one beat (called just after a negedge), return at the next negedge
   task automatic send(input bit sop, input bit eop, input logic [4:0] nb, input logic [DW-1:0] d);
      i_data_valid = 1'b1; i_data_sop = sop; i_data_eop = eop; i_data_bytes = nb; i_data = d;
      @(negedge i_clk);
   endtask

   task automatic idle(input int n);
      i_data_valid = 1'b0; i_data_sop = 1'b0; i_data_eop = 1'b0; i_data_bytes = 5'd0; i_data = '0;
      repeat (n) @(negedge i_clk);
   endtask

   function automatic logic [DW-1:0] fill(input logic [7:0] b);
      return {16{b}};
   endfunction

   initial begin
      repeat (2) @(negedge i_clk);
      chk("reset_head", o_head, '0);
      chk("reset_pkt_cnt", (HW+TW)'(o_pkt_cnt), '0);
      i_rst_n = 1'b1;
      idle(1);

      // 1: four-beat packet ending on a full eop beat
      send(1'b1, 1'b0, 5'd0, fill(8'h11));
      chk("t1_no_early_head", o_head, '0);
      send(1'b0, 1'b0, 5'd0, fill(8'h22));
      send(1'b0, 1'b0, 5'd0, fill(8'h33));
      send(1'b0, 1'b1, 5'd0, fill(8'h44));
      chk("t1_head", o_head, {fill(8'h11), fill(8'h22), fill(8'h33), fill(8'h44), 8'h80});
      chk("t1_meta", (HW+TW)'(o_meta), (HW+TW)'({16'd64, 240'd0, 8'h80}));
      chk("t1_pkt_cnt", (HW+TW)'(o_pkt_cnt), (HW+TW)'(32'd1));
      idle(1);
      chk("t1_head_after", o_head, '0);

      // 2: single beat with 5 valid bytes
      send(1'b1, 1'b1, 5'd5, 128'h0102030405060708090A0B0C0D0E0F10);
      chk("t2_head", o_head, {40'h0102030405, 472'd0, 8'h81});
      chk("t2_meta", (HW+TW)'(o_meta), (HW+TW)'({16'd5, 240'd0, 8'h81}));
      idle(2);

      // 3: six-beat packet, head emitted after beat 4, beats 5-6 dropped
      for (int k = 1; k <= 6; k++) begin
         send(k == 1, k == 6, 5'd0, fill(8'(8'hA0 + k)));
         if (k == 4) chk("t3_tag", (HW+TW)'(o_head[7:0]), (HW+TW)'(8'h82));
         if (k >= 5) chk("t3_drain_quiet", o_head, '0);
      end
      idle(1);

      // 4: missing eop, new sop discards the partial head
      send(1'b1, 1'b0, 5'd0, fill(8'h55));
      send(1'b0, 1'b0, 5'd0, fill(8'h66));
      send(1'b1, 1'b1, 5'd3, fill(8'h77));
      chk("t4_err_cnt", (HW+TW)'(o_err_cnt), (HW+TW)'(32'd1));
      chk("t4_head", o_head, {24'h777777, 488'd0, 8'h83});
      idle(1);

      // sop arriving while draining a long packet
      for (int k = 0; k < 5; k++) send(k == 0, 1'b0, 5'd0, fill(8'(k)));
      send(1'b1, 1'b1, 5'd0, fill(8'hC3));
      chk("drain_sop_err", (HW+TW)'(o_err_cnt), (HW+TW)'(32'd2));
      chk("drain_sop_tag", (HW+TW)'(o_head[7:0]), (HW+TW)'(8'h85));
      idle(1);

      // 5: orphan beat, then 130 back-to-back single-beat packets
      send(1'b0, 1'b0, 5'd0, fill(8'hEE));
      chk("t5_orphan_head", o_head, '0);
      chk("t5_orphan_err", (HW+TW)'(o_err_cnt), (HW+TW)'(32'd3));
      for (int k = 0; k < 130; k++) send(1'b1, 1'b1, 5'(k % 17), fill(8'(k)));
      chk("t5_last_tag", (HW+TW)'(o_head[7:0]), (HW+TW)'(8'h87));
      chk("t5_pkt_cnt", (HW+TW)'(o_pkt_cnt), (HW+TW)'(32'd136));
      idle(1);

      // 6: asynchronous reset in the middle of COLLECT
      send(1'b1, 1'b0, 5'd0, fill(8'h99));
      send(1'b0, 1'b0, 5'd0, fill(8'h98));
      i_data_valid = 1'b0;
      #2 i_rst_n = 1'b0;
      #1;
      chk("t6_rst_head", o_head, '0);
      chk("t6_rst_pkt_cnt", (HW+TW)'(o_pkt_cnt), '0);
      chk("t6_rst_err_cnt", (HW+TW)'(o_err_cnt), '0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      idle(1);
      send(1'b1, 1'b1, 5'd0, fill(8'h42));
      chk("t6_tag", (HW+TW)'(o_head[7:0]), (HW+TW)'(8'h80));
      chk("t6_pkt_cnt", (HW+TW)'(o_pkt_cnt), (HW+TW)'(32'd1));
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/parser_head_gen.md
Name: parser_head_gen

Overview:
- Front-end stage that feeds the first parser layer.
- Converts a streamed packet (DATA_WIDTH-bit beats, sop/eop framing) into one fixed-width, tagged head vector plus an initial tagged metadata vector.
- Emits exactly one head/meta pair per packet into the parser layer pipeline; the pipeline has no backpressure, so this block accepts one beat every cycle.
- Also keeps packet and error statistics.

Parameters:
DATA_WIDTH, 128, input beat width in bits (multiple of 8)
HEAD_WIDTH, 512, head vector width in bits; HEAD_BEATS = HEAD_WIDTH/DATA_WIDTH (integer, >=1)
META_WIDTH, 256, metadata width in bits (>=16)
TAG_WIDTH, 8, tag width; MSB = valid, low TAG_WIDTH-1 bits = packet id

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_data_valid  in  1  beat valid
i_data_sop  in  1  first beat of packet
i_data_eop  in  1  last beat of packet
i_data_bytes  in  $clog2(DATA_WIDTH/8)+1  valid bytes on eop beat (0 means full)
i_data  in  DATA_WIDTH  beat data, byte 0 in MSBs
o_head  out  HEAD_WIDTH+TAG_WIDTH  {head, tag} to first parser layer
o_meta  out  META_WIDTH+TAG_WIDTH  {meta, tag} to first parser layer
o_pkt_cnt  out  32  heads emitted
o_err_cnt  out  32  framing errors

Behaviour:
Interface and reset:
- One clock i_clk; reset i_rst_n is asynchronous and active-low.
- Reset clears all outputs, counters, head buffer and beat counter, forces state IDLE and sets packet id = 0.

States:
- IDLE: waiting for sop.
- COLLECT: filling the head buffer.
- DRAIN: head already emitted; discarding beats until eop.
- Beat counter is 0..HEAD_BEATS-1.

Head assembly:
- Beat k of the packet lands in head bits [HEAD_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH] (MSB-first).
- Unfilled beats are zero.
- On the eop beat, bytes at index >= i_data_bytes (nonzero) are zeroed.

Emission:
- Triggered by the beat that is either the HEAD_BEATS-th beat or an eop beat, whichever comes first.
- o_head and o_meta are registered and presented for exactly one cycle after that beat.
- Outputs are all-zero (tag included) on every other cycle.
- Tag = {1'b1, pkt_id}; the same tag is placed on o_head and o_meta.
- pkt_id increments after each emission and wraps modulo 2^(TAG_WIDTH-1).
- o_meta[META_WIDTH+TAG_WIDTH-1 -: 16] = number of valid head bytes, saturating at HEAD_WIDTH/8; remaining meta bits are 0.
- o_pkt_cnt increments on each emission and wraps at 2^32.

Transitions:
- IDLE + valid & sop:
  - with eop: emit, stay in IDLE.
  - with HEAD_BEATS==1 and no eop: emit, go to DRAIN.
  - otherwise: go to COLLECT.
- COLLECT + valid & !sop: store the beat.
  - on eop: emit, go to IDLE.
  - on last head beat without eop: emit, go to DRAIN.
- DRAIN + valid & eop: go to IDLE. Data in DRAIN is ignored.

Errors:
- valid & !sop in IDLE: beat dropped, o_err_cnt += 1.
- valid & sop in COLLECT: partial head discarded without emission, o_err_cnt += 1; the beat starts a new packet.
- valid & sop in DRAIN: o_err_cnt += 1; the beat starts a new packet.
- Only one error is counted per beat.
- Error counter wraps at 2^32.

Throughput and idle:
- Back-to-back single-beat packets emit one head per cycle.
- An emission and the next packet's sop may occur in the same cycle.
- While i_data_valid=0, state and buffer hold.

Mid-packet reset: the in-flight packet is lost, no emission occurs, and the next beat must be a sop.

Test Plan:
1. Reset, then a 4-beat packet with beats 0x11.., 0x22.., 0x33.., 0x44.. (eop, bytes=0) -> one cycle after beat 4: o_head = {beats 1..4, 8'h80}, meta top 16 = 64, o_pkt_cnt = 1; o_head = 0 on all other cycles.
2. Single-beat packet, sop&eop, bytes=5 -> head = top 5 bytes of beat followed by zeros, tag 8'h81, meta byte count = 5.
3. 6-beat packet -> emission the cycle after beat 4; beats 5-6 produce no output; the next sop is accepted normally.
4. sop, 2 beats, then a new sop (missing eop) -> o_err_cnt = 1, no emission for the first packet; the second packet emits with the next tag.
5. Orphan beat (valid, no sop) in IDLE -> o_err_cnt += 1, no output. Then 130 single-beat packets back-to-back -> one emission per cycle, tag id wraps 127 -> 0, o_pkt_cnt increases by 130.
6. Assert i_rst_n low mid-COLLECT -> outputs and counters are 0 immediately (asynchronous); a subsequent packet emits with tag 8'h80.
